// File: rtl/i2s_audio_pkg.sv
// Shared I2S audio definitions for the transmit and receive sides.
// Optional feature macro: I2S_TX_OFFSET_BINARY_EN (offset-binary sample input).
package i2s_audio_pkg;

    localparam int unsigned SAMPLE_W    = 24;
    localparam int unsigned SLOT_W      = 32;
    localparam int unsigned FRAME_SLOTS = 64;
    localparam int unsigned SLOT_CNT_W  = $clog2(FRAME_SLOTS);
    localparam int unsigned POS_W       = $clog2(SLOT_W);
    localparam int unsigned DIV_W       = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } sample_pair_t;

    // Convert an input sample to the two's complement line format.
    function automatic sample_t line_code(input sample_t s);
`ifdef I2S_TX_OFFSET_BINARY_EN
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
`else
        return s;
`endif
    endfunction

    // Serial bit for a slot: one-bit delay after the word edge, MSB first, zero padded.
    function automatic logic slot_bit(input logic [SLOT_CNT_W-1:0] slot,
                                      input sample_t left, input sample_t right);
        logic [POS_W-1:0] pos;
        sample_t          word;
        pos  = slot[POS_W-1:0];
        word = slot[SLOT_CNT_W-1] ? right : left;
        if (pos >= POS_W'(1) && pos <= POS_W'(SAMPLE_W)) begin
            return word[POS_W'(SAMPLE_W) - pos];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock generator: divides clk by 2*CLK_DIV and flags the cycles that toggle bclk.
module i2s_bclk_gen
    import i2s_audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic rise_c,
    output logic fall_c
);

    logic [DIV_W-1:0] div_q;
    logic             half_end_c;

    // Strobes mark the cycle whose closing edge moves bclk.
    assign half_end_c = (div_q == DIV_W'(CLK_DIV - 1));
    assign rise_c     = half_end_c && !bclk;
    assign fall_c     = half_end_c && bclk;

    // Half-period counter and bclk toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            bclk  <= 1'b0;
        end else if (half_end_c) begin
            div_q <= '0;
            bclk  <= ~bclk;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S stereo transmitter: 64-slot frame, 24-bit words, one holding register.
// Optional feature macro: I2S_TX_OFFSET_BINARY_EN (MSB inverted at frame load).
module i2s_audio_tx
    import i2s_audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mute,
    input  logic [23:0] lin,
    input  logic [23:0] rin,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        wclk,
    output logic        dout,
    output logic        underrun
);

    logic                  fall_c;
    logic                  unused_rise_c;
    logic                  accept_c;
    logic                  load_c;
    logic [SLOT_CNT_W-1:0] slot_q, slot_d;
    sample_pair_t          hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    sample_t               shl_q, shl_d;
    sample_t               shr_q, shr_d;
    logic                  wclk_d, dout_d, underrun_d;

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk    (clk),
        .rst    (rst),
        .bclk   (bclk),
        .rise_c (unused_rise_c),
        .fall_c (fall_c)
    );

    // Handshake and frame-boundary detection.
    assign accept_c = sample_valid && sample_ready;
    assign load_c   = fall_c && (slot_q == SLOT_CNT_W'(FRAME_SLOTS - 1));

    // Next-state: frame load, holding register fill, slot/serial output advance.
    always_comb begin
        slot_d      = slot_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shl_d       = shl_q;
        shr_d       = shr_q;
        wclk_d      = wclk;
        dout_d      = dout;
        underrun_d  = 1'b0;

        if (load_c) begin
            if (hold_full_q && !mute) begin
                shl_d = line_code(hold_q.left);
                shr_d = line_code(hold_q.right);
            end else begin
                shl_d = '0;
                shr_d = '0;
            end
            underrun_d  = !hold_full_q;
            hold_full_d = 1'b0;
        end

        // A pair accepted on the load cycle waits for the next frame.
        if (accept_c) begin
            hold_d.left  = lin;
            hold_d.right = rin;
            hold_full_d  = 1'b1;
        end

        // Slot 0 always carries 0, so the pre-load shift registers are safe to use here.
        if (fall_c) begin
            slot_d = slot_q + SLOT_CNT_W'(1);
            wclk_d = slot_d[SLOT_CNT_W-1];
            dout_d = slot_bit(slot_d, shl_q, shr_q);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= SLOT_CNT_W'(FRAME_SLOTS - 1);
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shl_q        <= '0;
            shr_q        <= '0;
            wclk         <= 1'b1;
            dout         <= 1'b0;
            underrun     <= 1'b0;
            sample_ready <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shl_q        <= shl_d;
            shr_q        <= shr_d;
            wclk         <= wclk_d;
            dout         <= dout_d;
            underrun     <= underrun_d;
            sample_ready <= !hold_full_d;
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed self-checking bench for i2s_audio_tx (CLK_DIV = 4, 512 clk per frame).
`timescale 1ns/1ps
module tb_i2s_audio_tx;

    localparam int unsigned CLK_DIV   = 4;
    localparam int          WAIT_MAX  = 2000;
    localparam logic [63:0] WCLK_EXP  = 64'hFFFF_FFFF_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mute;
    logic [23:0] lin, rin;
    logic        sample_valid;
    logic        sample_ready, bclk, wclk, dout, underrun;

    logic [23:0] man_l, man_r;
    logic        src_en;
    int unsigned src_idx;
    logic        bclk_d, wclk_d;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    // Manual data or a ramp indexed by the number of accepted pairs.
    assign lin = src_en ? 24'h000100 + 24'(src_idx) : man_l;
    assign rin = src_en ? 24'hF00000 + 24'(src_idx) : man_r;

    i2s_audio_tx #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mute         (mute),
        .lin          (lin),
        .rin          (rin),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .wclk         (wclk),
        .dout         (dout),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Edge history, cycle count since reset release, ramp index.
    always @(posedge clk) begin
        bclk_d <= bclk;
        wclk_d <= wclk;
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (!src_en)                          src_idx <= 0;
        else if (sample_valid && sample_ready) src_idx <= src_idx + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] enc(input logic [23:0] w);
`ifdef I2S_TX_OFFSET_BINARY_EN
        return w ^ 24'h800000;
`else
        return w;
`endif
    endfunction

    // Expected dout per slot (bit s = slot s) for a transmitted pair.
    function automatic logic [63:0] exp_pair(input logic [23:0] l_in, input logic [23:0] r_in);
        logic [63:0] f;
        logic [23:0] l, r, w;
        int          b;
        f = '0;
        l = enc(l_in);
        r = enc(r_in);
        for (int s = 0; s < 64; s++) begin
            b = (s % 32) - 1;
            w = (s < 32) ? l : r;
            if (b >= 0 && b <= 23) f[s] = w[23 - b];
        end
        return f;
    endfunction

    // Offer one pair for a single cycle, starting at the current negedge.
    task automatic offer(input logic [23:0] l, input logic [23:0] r);
        man_l        = l;
        man_r        = r;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Wait for the next frame start, then sample dout/wclk at each bclk rise.
    // At act_slot, raise mute and queue 24'h123456/24'h654321.
    task automatic capture(input int act_slot, output logic [63:0] bits, output logic [63:0] wbits,
                           output logic ur, output logic rdy_mid, output int start_cyc);
        int n;
        int late;
        n    = 0;
        late = 0;
        while (!(wclk === 1'b0 && wclk_d === 1'b1) && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) late++;
        ur        = underrun;
        start_cyc = cyc;
        rdy_mid   = 1'bx;
        for (int s = 0; s < 64; s++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(bclk === 1'b1 && bclk_d === 1'b0) && n < 64);
            if (n >= 64) late++;
            bits[s]  = dout;
            wbits[s] = wclk;
            if (s == 32) rdy_mid = sample_ready;
            if (s == act_slot) begin
                mute         = 1'b1;
                man_l        = 24'h123456;
                man_r        = 24'h654321;
                sample_valid = 1'b1;
            end
            if (s == act_slot + 1) sample_valid = 1'b0;
        end
        chk("capture_timeouts", 64'(late), 64'd0);
    endtask

    logic [63:0] bits, wbits;
    logic        ur, rdy;
    int          sc;

    initial begin
        rst          = 1'b1;
        mute         = 1'b0;
        sample_valid = 1'b0;
        man_l        = '0;
        man_r        = '0;
        src_en       = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_outputs", 64'({bclk, wclk, dout, underrun, sample_ready}), 64'b01000);

        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 64'(sample_ready), 64'd1);
        chk("wclk_before_first_load", 64'(wclk), 64'd1);

        // Frame 0: preloaded pair.
        offer(24'h800001, 24'h7FFFFE);
        chk("ready_low_after_accept", 64'(sample_ready), 64'd0);
        capture(99, bits, wbits, ur, rdy, sc);
        chk("f0_start_cycle", 64'(sc), 64'd8);
        chk("f0_underrun", 64'(ur), 64'd0);
        chk("f0_dout", bits, exp_pair(24'h800001, 24'h7FFFFE));
        chk("f0_wclk", wbits, WCLK_EXP);
        chk("f0_ready_mid", 64'(rdy), 64'd1);

        // Frame 1: nothing offered.
        capture(99, bits, wbits, ur, rdy, sc);
        chk("f1_start_cycle", 64'(sc), 64'd520);
        chk("f1_underrun", 64'(ur), 64'd1);
        chk("f1_dout", bits, 64'd0);

        // Frame 2: accept on the load cycle still underruns; frame 3 carries it.
        repeat (3) @(negedge clk);
        offer(24'hABCDEF, 24'h13579B);
        capture(99, bits, wbits, ur, rdy, sc);
        chk("f2_start_cycle", 64'(sc), 64'd1032);
        chk("f2_underrun", 64'(ur), 64'd1);
        chk("f2_dout", bits, 64'd0);
        chk("f2_ready_mid", 64'(rdy), 64'd0);
        capture(99, bits, wbits, ur, rdy, sc);
        chk("f3_underrun", 64'(ur), 64'd0);
        chk("f3_dout", bits, exp_pair(24'hABCDEF, 24'h13579B));
        chk("f3_wclk", wbits, WCLK_EXP);

        // Frames 4..7: continuous ramp, one pair per frame in order.
        src_en       = 1'b1;
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            capture(99, bits, wbits, ur, rdy, sc);
            chk($sformatf("ramp%0d_underrun", i), 64'(ur), 64'd0);
            chk($sformatf("ramp%0d_dout", i), bits, exp_pair(24'h000100 + 24'(i), 24'hF00000 + 24'(i)));
            chk($sformatf("ramp%0d_ready_mid", i), 64'(rdy), 64'd0);
        end
        src_en       = 1'b0;
        sample_valid = 1'b0;

        // Frame 8: last ramp pair; mute raised mid-frame with a pair queued.
        capture(40, bits, wbits, ur, rdy, sc);
        chk("f8_underrun", 64'(ur), 64'd0);
        chk("f8_dout", bits, exp_pair(24'h000104, 24'hF00004));
        chk("f8_ready_mid", 64'(rdy), 64'd1);

        // Frame 9: muted, queued pair consumed without underrun.
        capture(99, bits, wbits, ur, rdy, sc);
        chk("f9_underrun", 64'(ur), 64'd0);
        chk("f9_dout", bits, 64'd0);
        chk("f9_ready_mid", 64'(rdy), 64'd1);
        mute = 1'b0;

        // Frame 10: holding register was consumed, so underrun.
        capture(99, bits, wbits, ur, rdy, sc);
        chk("f10_underrun", 64'(ur), 64'd1);
        chk("f10_dout", bits, 64'd0);

        // Reset in slot 20 of frame 11 while bclk is high and dout is 1.
        offer(24'hFFFFFF, 24'h000000);
        repeat (3) @(negedge clk);
        chk("f11_started", 64'(wclk), 64'd0);
        repeat (20 * 2 * CLK_DIV + CLK_DIV) @(negedge clk);
        chk("pre_rst_state", 64'({bclk, wclk, dout}), 64'b101);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_outputs", 64'({bclk, wclk, dout, underrun, sample_ready}), 64'b01000);
        rst = 1'b0;
        capture(99, bits, wbits, ur, rdy, sc);
        chk("post_rst_start_cycle", 64'(sc), 64'd8);
        chk("post_rst_underrun", 64'(ur), 64'd1);
        chk("post_rst_dout", bits, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_audio_tx.md
I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per bclk half-period (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port mute, input, 1 bit: transmit zero samples while high.
REQ-005 SHALL have port lin, input, 24 bits: left sample.
REQ-006 SHALL have port rin, input, 24 bits: right sample.
REQ-007 SHALL have port sample_valid, input, 1 bit: lin/rin pair offered.
REQ-008 SHALL have port sample_ready, output, 1 bit: holding register empty.
REQ-009 SHALL have port bclk, output, 1 bit: serial bit clock (registered).
REQ-010 SHALL have port wclk, output, 1 bit: word select; 0 = left, 1 = right (registered).
REQ-011 SHALL have port dout, output, 1 bit: serial data (registered).
REQ-012 SHALL have port underrun, output, 1 bit: one-clk pulse on a frame load with an empty holding register.

Function
REQ-013 SHALL toggle bclk every CLK_DIV clk cycles, starting low: rising edge at cycle CLK_DIV, falling edge at cycle 2*CLK_DIV after reset release.
REQ-014 SHALL keep a 6-bit slot counter s (0..63) that advances only on bclk-falling cycles and wraps from 63 to 0; frame = 64 slots = 128*CLK_DIV clk cycles.
REQ-015 SHALL update wclk and dout only in bclk-falling cycles, so both are stable across each bclk rising edge.
REQ-016 SHALL drive wclk = 0 for s 0..31 and wclk = 1 for s 32..63.
REQ-017 SHALL use b = (s mod 32) - 1 (I2S one-bit delay): for b in 0..23, dout = word[23-b] (MSB first); for slot 0 and b in 24..30, dout = 0. word is the left shift register for s < 32 and the right shift register otherwise.
REQ-018 SHALL accept a pair into the holding register when sample_valid && sample_ready; sample_ready = !holding_full.
REQ-019 SHALL perform a frame load on the bclk-falling cycle that enters s = 0.
REQ-020 At a frame load with the holding register full, SHALL copy it to the left/right shift registers and clear holding_full in the same cycle.
REQ-021 At a frame load with the holding register empty, SHALL load zeros into both shift registers and pulse underrun for that single cycle.
REQ-022 An accept in the same cycle as a frame load SHALL fill the holding register; that data SHALL NOT be loaded in that cycle, and the cycle SHALL count as an underrun.
REQ-023 If mute is high at a frame load, SHALL load zeros but still consume the holding register; a mute change mid-frame SHALL take effect at the next frame.
REQ-024 SHALL leave the shift registers unchanged between frame loads; left and right always come from the same accepted pair.

Reset
REQ-025 While rst is high: bclk = 0, wclk = 1, dout = 0, underrun = 0, sample_ready = 0, s = 63, divider = 0, holding empty, shift registers = 0.
REQ-026 SHALL drive sample_ready = 1 from the first cycle after rst falls; the first frame load occurs at cycle 2*CLK_DIV (wclk 1 -> 0 edge).
REQ-027 rst asserted mid-frame SHALL abort the frame immediately and discard the holding contents.

Configuration
REQ-028 With macro I2S_TX_OFFSET_BINARY_EN defined, lin/rin SHALL be offset binary, and the MSB SHALL be inverted at frame load so the line carries two's complement; without it, lin/rin SHALL be two's complement and sent unmodified.

Structure
REQ-029 Package i2s_audio_pkg SHALL hold SAMPLE_W = 24, SLOT_W = 32 and FRAME_SLOTS = 64, shared with the receive side.
REQ-030 Sub-module i2s_bclk_gen SHALL own the CLK_DIV divider and output bclk plus one-clk rise and fall strobes.

Verification
REQ-031 CLK_DIV=4, lin=24'h800001, rin=24'h7FFFFE preloaded -> slots 1..24 = 1,0x22,1; slots 33..56 = 0,1x22,0; all other slots 0; wclk edges at s=0 and s=32.
REQ-032 No sample_valid after reset -> underrun pulses at cycle 8, then every 512 cycles; dout stays 0.
REQ-033 Continuous valid with ramp data -> each pair is transmitted exactly once, in order; sample_ready is low from accept until the next frame load.
REQ-034 mute raised at slot 40 with lin=24'h123456 queued -> the current frame completes unchanged, the next frame is all zeros, and the holding register is consumed.
REQ-035 rst pulsed at slot 20 -> outputs take reset values the next cycle, and the first load occurs 8 cycles after release.
REQ-036 I2S_TX_OFFSET_BINARY_EN defined, lin=24'h000000 -> the left slot carries 24'h800000 (slot 1 = 1, slots 2..24 = 0).
